// File: rtl/alu_arb_pkg.sv
// Shared types and constants for the shared-ALU arbiter: FSM states, op selects, default widths.
package alu_arb_pkg;

  localparam int unsigned DW_DEF = 4;
  localparam int unsigned SW_DEF = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

endpackage

// File: rtl/rr_arb2.sv
// Combinational 2-way round-robin grant; on contention the requester that did not win last time is picked.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_gnt,
  input  logic       enable,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  always_comb begin
    gnt    = '0;
    gnt_id = 1'b0;
    if (enable && (valid != 2'b00)) begin
      if (valid == 2'b11) begin
        gnt_id = ~last_gnt;
      end else begin
        gnt_id = valid[1];
      end
      gnt[gnt_id] = 1'b1;
    end
  end

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester front end for one external ALU: accept, register operands, capture result, respond with id.
// Optional grant counters enabled by ALU_SHARE_ARB_STATS_EN.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned SW = SW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [SW-1:0] req0_s,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [SW-1:0] req1_s,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SW-1:0] alu_s,
  input  logic [DW-1:0] alu_y,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_id
`ifdef ALU_SHARE_ARB_STATS_EN
  ,
  output logic [7:0]    gnt_cnt0,
  output logic [7:0]    gnt_cnt1
`endif
);

  state_t     state;
  logic       last_gnt;
  logic       id;
  logic [1:0] gnt;
  logic       gnt_id;

  rr_arb2 u_arb (
    .valid    ({req1_valid, req0_valid}),
    .last_gnt (last_gnt),
    .enable   (state == IDLE),
    .gnt      (gnt),
    .gnt_id   (gnt_id)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_s     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
      last_gnt  <= 1'b1;
      id        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt != 2'b00) begin
            alu_a    <= gnt_id ? req1_a : req0_a;
            alu_b    <= gnt_id ? req1_b : req0_b;
            alu_s    <= gnt_id ? req1_s : req0_s;
            id       <= gnt_id;
            last_gnt <= gnt_id;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_data  <= alu_y;
          rsp_id    <= id;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_SHARE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0 <= '0;
      gnt_cnt1 <= '0;
    end else begin
      if (gnt[0] && (gnt_cnt0 != 8'hff)) gnt_cnt0 <= gnt_cnt0 + 8'd1;
      if (gnt[1] && (gnt_cnt1 != 8'hff)) gnt_cnt1 <= gnt_cnt1 + 8'd1;
    end
  end
`endif

endmodule
